ahb_lite_slave_mem: RTL and testbench
=====================================

// Module: ahb_lite_slave_mem
// PURPOSE
//  AHB-Lite slave: word-addressed on-chip RAM with a read-only window.
//  Attaches to the slave side of the AHB-Lite bus (HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA in; HREADY/HRESP/HRDATA out).
//  Serves SINGLE and INCR4/8/16 bursts, including master BUSY cycles.
//  Signals ERROR for illegal accesses using the two-cycle AHB error response.
// PARAMETERS
//  ADDRESS_WIDTH  32  HADDR width; memory is word-addressed (each beat is addr+1).
//  DATA_WIDTH     32  HRDATA/HWDATA width.
//  MEM_DEPTH      256 Number of words; valid addresses are 0..MEM_DEPTH-1.
//  RO_BASE        192 First read-only word address.
//  RO_LIMIT       255 Last read-only word address (inclusive).
//  WAIT_STATES    0   HREADY-low cycles inserted at the start of every OKAY data phase (0..7).
// PORTS
//  HCLK     in   1              Bus clock, rising edge.
//  HRESETn  in   1              Asynchronous, active-low reset.
//  HADDR    in   ADDRESS_WIDTH  Word address (address phase).
//  HWRITE   in   1              1 = write, 0 = read.
//  HSIZE    in   3              Transfer size; 3'b010 = word.
//  HBURST   in   3              Burst type; 000 SINGLE, 011 INCR4, 101 INCR8, 111 INCR16.
//  HTRANS   in   2              00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
//  HWDATA   in   DATA_WIDTH     Write data (data phase).
//  HRDATA   out  DATA_WIDTH     Read data (data phase).
//  HREADY   out  1              1 = data phase completes this cycle.
//  HRESP    out  1              0 = OKAY, 1 = ERROR.
// BEHAVIOUR
//  - Reset: HREADY=1, HRESP=0, HRDATA=0, data-phase state cleared to idle. RAM contents are not reset.
//  - Address phase is sampled on a HCLK rise with HREADY=1. It is active only when HTRANS is NONSEQ or SEQ.
//  - IDLE and BUSY: zero-wait OKAY, no memory access, HRDATA holds its last value.
//  - On an active sample, register addr, write, and access class for the data phase in the next cycle.
//  - Access classes:
//    - ERROR if addr >= MEM_DEPTH.
//    - ERROR if HSIZE > log2(DATA_WIDTH/8).
//    - ERROR if the access is a write and RO_BASE <= addr <= RO_LIMIT.
//    - Otherwise OKAY. Sizes below word are treated as full-word accesses.
//  - OKAY data phase:
//    - Hold HREADY=0 for WAIT_STATES cycles, then HREADY=1, HRESP=0.
//    - Read: HRDATA = mem[addr_q] throughout the data phase, so it is valid at the HREADY=1 edge.
//    - Write: mem[addr_q] <= HWDATA on the edge where HREADY=1.
//  - ERROR data phase, two cycles, no memory change:
//    - Cycle 1: HREADY=0, HRESP=1.
//    - Cycle 2: HREADY=1, HRESP=1.
//    - A new address phase is sampled at the end of cycle 2 (the master may cancel with IDLE).
//  - Pipelining: a new address phase overlaps the current data phase. Back-to-back NONSEQ/SEQ run at 1 beat/cycle when WAIT_STATES=0.
//  - Read-after-write to the same address in consecutive transfers returns the new data (write commits before the read data phase).
//  - HBURST is informational only: every beat is decoded from its own HADDR. No burst counter, no 1KB-boundary logic.
//  - A SEQ with no preceding NONSEQ is serviced like NONSEQ.
//  - Inputs are sampled only while HREADY=1. Inputs are ignored during wait/error cycles.
//  - HRESETn asserted mid-transfer aborts immediately: outputs go to reset values and the pending write is dropped.
// TESTING
//  - Reset: HRESETn=0 mid-burst -> HREADY=1, HRESP=0, HRDATA=0 asynchronously; no write committed.
//  - Single write/read: NONSEQ write addr 0x10, data 0xDEADBEEF; then NONSEQ read 0x10 -> HRDATA=0xDEADBEEF, HRESP=0.
//  - INCR4 write then read:
//    - Write addr 0x20..0x23, data 0x1,0x2,0x3,0x4 (NONSEQ+3 SEQ).
//    - INCR4 read of the same addresses returns 0x1..0x4 on 4 consecutive data phases.
//  - BUSY insertion:
//    - INCR8 read at 0x40 with 2 BUSY cycles after beat 2 -> 8 correct words.
//    - No extra memory access during the BUSY cycles.
//  - Read-only: write 0xC0 (192) data 0x55 -> HREADY=0/HRESP=1, then HREADY=1/HRESP=1; a later read of 0xC0 returns the prior content.
//  - Range/size/wait:
//    - Read addr 256 -> 2-cycle ERROR.
//    - HSIZE=3'b011 -> ERROR.
//    - With WAIT_STATES=2, a single read shows HREADY low for exactly 2 cycles before the data.

Source files
------------

// File: rtl/ahb_lite_slave_mem.sv
`default_nettype none
// ahb_lite_slave_mem: AHB-Lite word-addressed RAM slave with a read-only window,
// optional wait states on OKAY transfers and the two-cycle ERROR response.
module ahb_lite_slave_mem #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_DEPTH     = 256,
  parameter int RO_BASE       = 192,
  parameter int RO_LIMIT      = 255,
  parameter int WAIT_STATES   = 0
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [ADDRESS_WIDTH-1:0] HADDR,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [2:0]               HBURST,
  input  logic [1:0]               HTRANS,
  input  logic [DATA_WIDTH-1:0]    HWDATA,
  output logic [DATA_WIDTH-1:0]    HRDATA,
  output logic                     HREADY,
  output logic                     HRESP
);

  localparam int                     IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [2:0]             MAX_SIZE  = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [2:0]             WAIT_LAST = 3'(WAIT_STATES);
  localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(MEM_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] RO_LO_A = ADDRESS_WIDTH'(RO_BASE);
  localparam logic [ADDRESS_WIDTH-1:0] RO_HI_A = ADDRESS_WIDTH'(RO_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OKAY = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [IDX_W-1:0]      addr_q;
  logic                  write_q;
  logic [2:0]            wait_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic ready;
  logic accept;
  logic access_err;
  logic okay_done;
  logic mem_we;
  logic unused_inputs;

  assign unused_inputs = ^{HBURST, HTRANS[0]};

  assign ready     = (state == ST_OKAY) ? (wait_cnt == WAIT_LAST) : (state != ST_ERR1);
  assign accept    = ready && HTRANS[1];
  assign okay_done = (state == ST_OKAY) && ready;
  assign mem_we    = okay_done && write_q;

  assign access_err = (HADDR >= DEPTH_A) || (HSIZE > MAX_SIZE) ||
                      (HWRITE && (HADDR >= RO_LO_A) && (HADDR <= RO_HI_A));

  assign HREADY = ready;
  assign HRESP  = (state == ST_ERR1) || (state == ST_ERR2);
  // Read data is driven straight from the array for the whole data phase so a
  // write committed on the previous edge is visible without a bypass path.
  assign HRDATA = (state == ST_OKAY && !write_q) ? mem[addr_q] : rdata_q;

  always_comb begin
    state_nxt = state;
    if (ready) begin
      if (!accept)         state_nxt = ST_IDLE;
      else if (access_err) state_nxt = ST_ERR1;
      else                 state_nxt = ST_OKAY;
    end else if (state == ST_ERR1) begin
      state_nxt = ST_ERR2;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wait_cnt <= '0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= HADDR[IDX_W-1:0];
        write_q <= HWRITE;
      end
      if (ready)                  wait_cnt <= '0;
      else if (state == ST_OKAY)  wait_cnt <= wait_cnt + 3'd1;
      if (okay_done && !write_q)  rdata_q  <= mem[addr_q];
    end
  end

  always_ff @(posedge HCLK) begin
    if (mem_we) mem[addr_q] <= HWDATA;
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_slave_mem.sv
`default_nettype none
// tb_ahb_lite_slave_mem: directed and randomized AHB-Lite traffic checked against
// a transaction-level memory model, plus a wait-state instance.
module tb_ahb_lite_slave_mem;

  localparam int DEPTH = 256;
  localparam int RO_LO = 192;
  localparam int RO_HI = 255;
  localparam int WS0   = 0;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hready, hresp;
  logic [2:0]  hsize, hburst;
  logic [1:0]  htrans;

  logic [31:0] ws_haddr, ws_hwdata, ws_hrdata;
  logic        ws_hwrite, ws_hready, ws_hresp;
  logic [2:0]  ws_hsize, ws_hburst;
  logic [1:0]  ws_htrans;

  ahb_lite_slave_mem #(.WAIT_STATES(WS0)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HTRANS(htrans), .HWDATA(hwdata), .HRDATA(hrdata),
    .HREADY(hready), .HRESP(hresp)
  );

  ahb_lite_slave_mem #(.WAIT_STATES(2)) dut_ws (
    .HCLK(clk), .HRESETn(rst_n), .HADDR(ws_haddr), .HWRITE(ws_hwrite), .HSIZE(ws_hsize),
    .HBURST(ws_hburst), .HTRANS(ws_htrans), .HWDATA(ws_hwdata), .HRDATA(ws_hrdata),
    .HREADY(ws_hready), .HRESP(ws_hresp)
  );

  typedef struct packed {
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] ref_mem [DEPTH];
  bit          ref_known [DEPTH];
  logic [31:0] last_rdata;
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add(input logic [1:0] t, input logic w, input int a, input logic [2:0] s,
                     input logic [31:0] d, input logic [2:0] b);
    q.push_back('{trans: t, write: w, addr: 32'(a), size: s, burst: b, wdata: d});
  endtask

  function automatic bit is_err(input xfer_t x);
    return (x.addr >= 32'(DEPTH)) || (x.size > 3'd2) ||
           (x.write && x.addr >= 32'(RO_LO) && x.addr <= 32'(RO_HI));
  endfunction

  task automatic drive(input int idx, input xfer_t pend, input bit pend_v);
    if (idx < q.size()) begin
      htrans = q[idx].trans;  hwrite = q[idx].write;  haddr = q[idx].addr;
      hsize  = q[idx].size;   hburst = q[idx].burst;
    end else begin
      htrans = T_IDLE; hwrite = 1'b0; haddr = '0; hsize = 3'd2; hburst = 3'd0;
    end
    hwdata = (pend_v && pend.write) ? pend.wdata : $urandom;
  endtask

  // Plays the queued address phases as a pipelined master; the expected
  // response of each data phase follows from its access class alone.
  task automatic run_seq();
    xfer_t pend = '0;
    bit    pend_v = 1'b0, pend_err = 1'b0, exp_ready, exp_resp;
    int    pend_cyc = 0, idx = 0, guard = 0, a;
    drive(idx, pend, pend_v);
    while (idx < q.size() || pend_v) begin
      @(negedge clk);
      exp_ready = 1'b1;
      exp_resp  = 1'b0;
      a = int'(pend.addr[7:0]);
      if (pend_v) begin
        if (pend_err) begin
          exp_resp  = 1'b1;
          exp_ready = (pend_cyc == 1);
        end else begin
          exp_ready = (pend_cyc >= WS0);
        end
      end
      check("hready", 32'(hready), 32'(exp_ready));
      check("hresp", 32'(hresp), 32'(exp_resp));
      if (pend_v && !pend_err && !pend.write && exp_ready) begin
        if (ref_known[a]) check("rdata", hrdata, ref_mem[a]);
        else begin
          ref_mem[a]   = hrdata;
          ref_known[a] = 1'b1;
        end
        last_rdata = ref_mem[a];
      end else if (!pend_v) begin
        check("rdata_hold", hrdata, last_rdata);
      end
      @(posedge clk);
      if (exp_ready) begin
        if (pend_v && !pend_err && pend.write) begin
          ref_mem[a]   = pend.wdata;
          ref_known[a] = 1'b1;
        end
        pend_v = 1'b0;
        if (idx < q.size()) begin
          if (q[idx].trans[1]) begin
            pend     = q[idx];
            pend_v   = 1'b1;
            pend_err = is_err(pend);
            pend_cyc = 0;
          end
          idx++;
        end
      end else begin
        pend_cyc++;
      end
      #1;
      drive(idx, pend, pend_v);
      guard++;
      if (guard > 20000) begin
        check("seq_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    q.delete();
  endtask

  task automatic ws_count(input string tag, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ws_hready) break;
      n++;
    end
    check(tag, 32'(n), 32'd2);
  endtask

  initial begin
    int n;
    int r;
    logic [1:0] t;
    int a;

    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
    last_rdata = '0;
    htrans = T_IDLE; hwrite = 1'b0; haddr = '0; hsize = 3'd2; hburst = 3'd0; hwdata = '0;
    ws_htrans = T_IDLE; ws_hwrite = 1'b0; ws_haddr = '0; ws_hsize = 3'd2; ws_hburst = 3'd0;
    ws_hwdata = '0;
    rst_n = 1'b0;
    #12;
    check("rst_hready", 32'(hready), 32'd1);
    check("rst_hresp", 32'(hresp), 32'd0);
    check("rst_hrdata", hrdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single write then read
    add(T_NSEQ, 1'b1, 'h10, 3'd2, 32'hDEADBEEF, 3'b000);
    add(T_NSEQ, 1'b0, 'h10, 3'd2, 32'h0, 3'b000);
    // INCR4 write then read, back to back
    for (int i = 0; i < 4; i++) add(i == 0 ? T_NSEQ : T_SEQ, 1'b1, 'h20 + i, 3'd2, 32'(i + 1), 3'b011);
    for (int i = 0; i < 4; i++) add(i == 0 ? T_NSEQ : T_SEQ, 1'b0, 'h20 + i, 3'd2, 32'h0, 3'b011);
    // INCR8 fill, then read with two BUSY cycles after beat 2
    for (int i = 0; i < 8; i++) add(i == 0 ? T_NSEQ : T_SEQ, 1'b1, 'h40 + i, 3'd2, 32'h100 + 32'(i), 3'b101);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        add(T_BUSY, 1'b0, 'h42, 3'd2, 32'h0, 3'b101);
        add(T_BUSY, 1'b0, 'h42, 3'd2, 32'h0, 3'b101);
      end
      add(i == 0 ? T_NSEQ : T_SEQ, 1'b0, 'h40 + i, 3'd2, 32'h0, 3'b101);
    end
    // read-only window, out of range, oversize, then recovery
    add(T_NSEQ, 1'b0, 'hC0, 3'd2, 32'h0, 3'b000);
    add(T_NSEQ, 1'b1, 'hC0, 3'd2, 32'h55, 3'b000);
    add(T_NSEQ, 1'b0, 'hC0, 3'd2, 32'h0, 3'b000);
    add(T_NSEQ, 1'b0, 256, 3'd2, 32'h0, 3'b000);
    add(T_NSEQ, 1'b0, 'h11, 3'd3, 32'h0, 3'b000);
    add(T_NSEQ, 1'b0, 'h10, 3'd2, 32'h0, 3'b000);
    add(T_SEQ, 1'b0, 'h21, 3'd0, 32'h0, 3'b000);
    run_seq();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      t = (r < 2) ? T_IDLE : (r < 3) ? T_BUSY : (r < 6) ? T_NSEQ : T_SEQ;
      case ($urandom_range(0, 3))
        0, 3:    a = $urandom_range(0, 15);
        1:       a = $urandom_range(186, 199);
        default: a = $urandom_range(250, 262);
      endcase
      add(t, 1'($urandom_range(0, 1)), a,
          ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
          $urandom, 3'($urandom_range(0, 7)));
    end
    run_seq();

    // asynchronous reset during a write data phase drops the write
    add(T_NSEQ, 1'b1, 'h30, 3'd2, 32'h12345678, 3'b011);
    add(T_SEQ, 1'b0, 'h30, 3'd2, 32'h0, 3'b011);
    run_seq();
    htrans = T_NSEQ; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2; hburst = 3'b011;
    @(posedge clk); #1;
    htrans = T_SEQ; hwrite = 1'b1; haddr = 32'h31; hwdata = 32'hBAD0BAD0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_hready", 32'(hready), 32'd1);
    check("arst_hresp", 32'(hresp), 32'd0);
    check("arst_hrdata", hrdata, 32'd0);
    htrans = T_IDLE; hwrite = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_rdata = '0;
    @(posedge clk); #1;
    add(T_NSEQ, 1'b0, 'h30, 3'd2, 32'h0, 3'b000);
    run_seq();

    // wait-state instance: both data phases show exactly two low cycles
    ws_htrans = T_NSEQ; ws_hwrite = 1'b1; ws_haddr = 32'h5;
    @(posedge clk); #1;
    ws_htrans = T_IDLE; ws_hwrite = 1'b0; ws_hwdata = 32'hA5A50F0F;
    ws_count("ws_write_wait", n);
    @(posedge clk); #1;
    ws_htrans = T_NSEQ; ws_haddr = 32'h5;
    @(posedge clk); #1;
    ws_htrans = T_IDLE;
    ws_count("ws_read_wait", n);
    check("ws_rdata", ws_hrdata, 32'hA5A50F0F);
    check("ws_hresp", 32'(ws_hresp), 32'd0);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
